// File: rtl/cv32e40p_tb_ctrl_pkg.sv
// Shared constants and types for the testbench control peripheral.
// Optional timer block is enabled with CV32E40P_TB_CTRL_TIMER_EN.
package cv32e40p_tb_ctrl_pkg;

  localparam logic [31:0] TB_CTRL_STDOUT_ADDR = 32'h1000_0000;
  localparam logic [31:0] TB_CTRL_STATUS_ADDR = 32'h2000_0000;
  localparam logic [31:0] TB_CTRL_EXIT_ADDR   = 32'h2000_0004;
  localparam logic [31:0] TB_CTRL_TIMER_ADDR  = 32'h1500_0000;
  localparam logic [31:0] TB_CTRL_PASS_MAGIC  = 32'd123456789;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} tb_ctrl_state_e;

  typedef enum logic [1:0] {NONE, PASS, FAIL, EXIT} tb_ctrl_kind_e;

  // Word-granular address compare; byte offset bits are don't-care.
  function automatic logic word_hit(logic [31:0] addr, logic [31:0] base);
    return addr[31:2] == base[31:2];
  endfunction

endpackage

// File: rtl/cv32e40p_tb_ctrl_fifo.sv
// First-word-fall-through 8-bit FIFO for buffered stdout characters.
// Output holds the last popped character while the FIFO is empty.
module cv32e40p_tb_ctrl_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  last_q;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = empty_o ? last_q : mem_q[rd_ptr_q[AW-1:0]];

  // Character storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  // Pointer advance and retention of the last character handed out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        last_q   <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/cv32e40p_tb_ctrl_periph.sv
// Testbench control peripheral: stdout FIFO, pass/fail/exit reporting that
// waits for stdout to drain, and an optional free-running timer.
// Timer present only when CV32E40P_TB_CTRL_TIMER_EN is defined.
module cv32e40p_tb_ctrl_periph #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [31:0] STDOUT_ADDR = cv32e40p_tb_ctrl_pkg::TB_CTRL_STDOUT_ADDR,
  parameter logic [31:0] STATUS_ADDR = cv32e40p_tb_ctrl_pkg::TB_CTRL_STATUS_ADDR,
  parameter logic [31:0] EXIT_ADDR   = cv32e40p_tb_ctrl_pkg::TB_CTRL_EXIT_ADDR,
  parameter logic [31:0] TIMER_ADDR  = cv32e40p_tb_ctrl_pkg::TB_CTRL_TIMER_ADDR,
  parameter logic [31:0] PASS_MAGIC  = cv32e40p_tb_ctrl_pkg::TB_CTRL_PASS_MAGIC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  import cv32e40p_tb_ctrl_pkg::*;

  tb_ctrl_state_e state_q, state_d;
  tb_ctrl_kind_e  kind_q, kind_d;
  logic [31:0]    exit_val_q, exit_val_d;

  logic        stdout_hit, status_hit, exit_hit, tmr_ctrl_hit, tmr_cnt_hit;
  logic        wr_acc, rd_acc, push, pop, fifo_full, fifo_empty;
  logic [31:0] timer_cnt;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        unused_sig;

  assign unused_sig = ^{be_i, addr_i[1:0]};

  assign stdout_hit = word_hit(addr_i, STDOUT_ADDR);
  assign status_hit = word_hit(addr_i, STATUS_ADDR);
  assign exit_hit   = word_hit(addr_i, EXIT_ADDR);

  // Only a stdout write into a full FIFO is stalled; a same-cycle pop is not
  // credited, so the push simply retries one cycle later.
  assign gnt_o  = req_i & ~(we_i & stdout_hit & fifo_full);
  assign wr_acc = gnt_o & we_i;
  assign rd_acc = gnt_o & ~we_i;
  assign push   = wr_acc & stdout_hit;
  assign pop    = char_valid_o & char_ready_i;

  assign char_valid_o = ~fifo_empty;

  cv32e40p_tb_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (wdata_i[7:0]),
    .pop_i   (pop),
    .data_o  (char_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef CV32E40P_TB_CTRL_TIMER_EN
  logic        timer_run_q;
  logic [31:0] timer_cnt_q;

  assign tmr_ctrl_hit = word_hit(addr_i, TIMER_ADDR);
  assign tmr_cnt_hit  = word_hit(addr_i, TIMER_ADDR + 32'd4);
  assign timer_cnt    = timer_cnt_q;

  // Timer control: start clears the count, stop freezes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_run_q <= 1'b0;
      timer_cnt_q <= '0;
    end else if (wr_acc && tmr_ctrl_hit) begin
      timer_run_q <= wdata_i[0];
      if (wdata_i[0]) timer_cnt_q <= '0;
    end else if (timer_run_q) begin
      timer_cnt_q <= timer_cnt_q + 32'd1;
    end
  end
`else
  logic unused_timer;

  assign unused_timer = ^TIMER_ADDR;
  assign tmr_ctrl_hit = 1'b0;
  assign tmr_cnt_hit  = 1'b0;
  assign timer_cnt    = '0;
`endif

  // Bus response: one cycle after every grant, data only for counter reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt_o;
      rdata_q  <= (rd_acc && tmr_cnt_hit && !tmr_ctrl_hit) ? timer_cnt : '0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

  // Report state register: what was armed, and how far draining has got.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      kind_q     <= NONE;
      exit_val_q <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      exit_val_q <= exit_val_d;
    end
  end

  // Next state and sticky report outputs; only the first STATUS/EXIT arms.
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    exit_val_d     = exit_val_q;
    tests_passed_o = 1'b0;
    tests_failed_o = 1'b0;
    exit_valid_o   = 1'b0;
    exit_value_o   = '0;
    case (state_q)
      RUN: begin
        if (wr_acc && status_hit) begin
          kind_d  = (wdata_i == PASS_MAGIC) ? PASS : FAIL;
          state_d = DRAIN;
        end else if (wr_acc && exit_hit) begin
          kind_d     = EXIT;
          exit_val_d = wdata_i;
          state_d    = DRAIN;
        end
      end
      // A push landing on the cycle the FIFO empties must still drain first.
      DRAIN: if (fifo_empty && !push) state_d = DONE;
      DONE: begin
        case (kind_q)
          PASS: tests_passed_o = 1'b1;
          FAIL: tests_failed_o = 1'b1;
          EXIT: begin
            exit_valid_o = 1'b1;
            exit_value_o = exit_val_q;
          end
          default: ;
        endcase
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_cv32e40p_tb_ctrl_periph.sv
// Scoreboard bench for cv32e40p_tb_ctrl_periph: stimulus pushes expected bus
// responses and characters into queues, a negedge monitor pops and compares.
module tb_cv32e40p_tb_ctrl_periph;

  localparam logic [31:0] A_STDOUT = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h2000_0000;
  localparam logic [31:0] A_EXIT   = 32'h2000_0004;
  localparam logic [31:0] A_TCTRL  = 32'h1500_0000;
  localparam logic [31:0] A_TCNT   = 32'h1500_0004;
  localparam logic [31:0] A_UNMAP  = 32'h3000_0000;
  localparam logic [31:0] MAGIC    = 32'd123456789;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        char_ready = 1'b0;
  logic        gnt, rvalid, char_valid, passed, failed, exit_valid;
  logic [31:0] rdata, exit_value;
  logic [7:0]  char_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    string       name;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [7:0]  ch_q[$];
  logic [31:0] rd_log[$];
  rd_exp_t     mon_e;
  logic [7:0]  mon_c;
  logic [31:0] tlo, thi;

  always #5 clk = ~clk;

  cv32e40p_tb_ctrl_periph dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .gnt_o          (gnt),
    .we_i           (we),
    .be_i           (be),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .rvalid_o       (rvalid),
    .rdata_o        (rdata),
    .char_valid_o   (char_valid),
    .char_o         (char_out),
    .char_ready_i   (char_ready),
    .tests_passed_o (passed),
    .tests_failed_o (failed),
    .exit_valid_o   (exit_valid),
    .exit_value_o   (exit_value)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every bus response and every accepted character.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid) begin
        n_vec++;
        rd_log.push_back(rdata);
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL rvalid_unexpected: got rdata %h with no request outstanding", rdata);
        end else begin
          mon_e = rd_q.pop_front();
          if (rdata < mon_e.lo || rdata > mon_e.hi) begin
            n_err++;
            $display("FAIL %s: rdata %0d expected %0d..%0d", mon_e.name, rdata, mon_e.lo, mon_e.hi);
          end
        end
      end
      if (char_valid && char_ready) begin
        n_vec++;
        if (ch_q.size() == 0) begin
          n_err++;
          $display("FAIL char_unexpected: got %h with none expected", char_out);
        end else begin
          mon_c = ch_q.pop_front();
          if (char_out !== mon_c) begin
            n_err++;
            $display("FAIL char_stream: got %h expected %h", char_out, mon_c);
          end
        end
      end
    end
  end

  // One bus access; grant wait is bounded and expectations queued on grant.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] lo, input logic [31:0] hi, input string nm);
    int unsigned cyc;
    cyc = 0;
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    do begin
      @(negedge clk);
      cyc++;
    end while (!gnt && cyc < 40);
    n_vec++;
    if (!gnt) begin
      n_err++;
      $display("FAIL %s_grant: gnt 0 after %0d cycles, required 1", nm, cyc);
    end else begin
      rd_q.push_back('{lo, hi, nm});
      if (w && a == A_STDOUT) ch_q.push_back(d[7:0]);
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {31'd0, gnt}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_char_valid"}, {31'd0, char_valid}, 32'd0);
    chk({tag, "_char"}, {24'd0, char_out}, 32'd0);
    chk({tag, "_passed"}, {31'd0, passed}, 32'd0);
    chk({tag, "_failed"}, {31'd0, failed}, 32'd0);
    chk({tag, "_exit_valid"}, {31'd0, exit_valid}, 32'd0);
    chk({tag, "_exit_value"}, exit_value, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    ch_q.delete();
    rd_q.delete();
    @(negedge clk);
    chk_all_zero(tag);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // "Hi\n" with the consumer always ready
    char_ready = 1'b1;
    bus(1'b1, A_STDOUT, 32'h48, 0, 0, "wr_H");
    @(negedge clk); chk("H_visible", {31'd0, char_valid}, 32'd1);
    bus(1'b1, A_STDOUT, 32'h69, 0, 0, "wr_i");
    @(negedge clk); chk("i_visible", {31'd0, char_valid}, 32'd1);
    bus(1'b1, A_STDOUT, 32'h0A, 0, 0, "wr_nl");
    @(negedge clk); chk("nl_visible", {31'd0, char_valid}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hi_drained", 32'(ch_q.size()), 32'd0);
    chk("hi_empty", {31'd0, char_valid}, 32'd0);
    chk("hi_char_hold", {24'd0, char_out}, 32'h0A);

    // Fill the FIFO with the consumer stalled, then a 17th write
    @(posedge clk); #1;
    char_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus(1'b1, A_STDOUT, 32'h50 + 32'(i), 0, 0, "wr_fill");
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = A_STDOUT; wdata = 32'h60;
    repeat (3) begin
      @(negedge clk);
      chk("gnt_full", {31'd0, gnt}, 32'd0);
    end
    @(posedge clk); #1;
    char_ready = 1'b1;
    @(negedge clk); chk("gnt_full_pop", {31'd0, gnt}, 32'd0);
    @(negedge clk); chk("gnt_after_pop", {31'd0, gnt}, 32'd1);
    rd_q.push_back('{32'd0, 32'd0, "wr_17"});
    ch_q.push_back(8'h60);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("fill_drained", 32'(ch_q.size()), 32'd0);

    // Pass reported only after buffered chars drain
    @(posedge clk); #1;
    char_ready = 1'b0;
    bus(1'b1, A_STDOUT, 32'h41, 0, 0, "wr_A");
    bus(1'b1, A_STDOUT, 32'h42, 0, 0, "wr_B");
    bus(1'b1, A_STDOUT, 32'h43, 0, 0, "wr_C");
    bus(1'b1, A_STATUS, MAGIC, 0, 0, "wr_status_pass");
    repeat (3) @(posedge clk);
    @(negedge clk); chk("pass_held_while_buffered", {31'd0, passed}, 32'd0);
    @(posedge clk); #1;
    char_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); chk("pass_not_yet", {31'd0, passed}, 32'd0);
    @(negedge clk);
    chk("pass_rise", {31'd0, passed}, 32'd1);
    chk("pass_no_fail", {31'd0, failed}, 32'd0);
    chk("pass_no_exit", {31'd0, exit_valid}, 32'd0);
    bus(1'b1, A_STATUS, 32'd1, 0, 0, "wr_status_late");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("late_status_pass", {31'd0, passed}, 32'd1);
    chk("late_status_fail", {31'd0, failed}, 32'd0);

    // Exit first, then a failing status
    do_reset("rst_a");
    bus(1'b1, A_EXIT, 32'd5, 0, 0, "wr_exit");
    bus(1'b1, A_STATUS, 32'd1, 0, 0, "wr_status_fail");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("exit_valid", {31'd0, exit_valid}, 32'd1);
    chk("exit_value", exit_value, 32'd5);
    chk("exit_no_fail", {31'd0, failed}, 32'd0);
    chk("exit_no_pass", {31'd0, passed}, 32'd0);

    // Plain reads and unmapped accesses
    bus(1'b0, A_UNMAP, 32'd0, 0, 0, "rd_unmapped");
    bus(1'b0, A_STDOUT, 32'd0, 0, 0, "rd_stdout");
    bus(1'b1, A_UNMAP, 32'hDEAD_BEEF, 0, 0, "wr_unmapped");

    // Timer
`ifdef CV32E40P_TB_CTRL_TIMER_EN
    tlo = 32'd10; thi = 32'd12;
`else
    tlo = 32'd0; thi = 32'd0;
`endif
    bus(1'b1, A_TCTRL, 32'd1, 0, 0, "wr_timer_start");
    repeat (10) @(posedge clk);
    bus(1'b0, A_TCNT, 32'd0, tlo, thi, "rd_timer_run");
`ifdef CV32E40P_TB_CTRL_TIMER_EN
    tlo = 32'd12; thi = 32'd14;
`endif
    bus(1'b1, A_TCTRL, 32'd0, 0, 0, "wr_timer_stop");
    bus(1'b0, A_TCNT, 32'd0, tlo, thi, "rd_timer_stop1");
    repeat (3) @(posedge clk);
    bus(1'b0, A_TCNT, 32'd0, tlo, thi, "rd_timer_stop2");
    @(negedge clk); #1;
    chk("timer_stopped_equal", rd_log[rd_log.size()-1], rd_log[rd_log.size()-2]);

    // Reset in the middle of a drain
    do_reset("rst_b");
    @(posedge clk); #1;
    char_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus(1'b1, A_STDOUT, 32'h70 + 32'(i), 0, 0, "wr_pre_rst");
    bus(1'b1, A_STATUS, MAGIC, 0, 0, "wr_status_pre_rst");
    @(negedge clk);
    chk("pre_rst_buffered", {31'd0, char_valid}, 32'd1);
    do_reset("rst_drain");
    @(posedge clk); #1;
    char_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_no_char", {31'd0, char_valid}, 32'd0);
    end
    chk("post_rst_no_pass", {31'd0, passed}, 32'd0);

    // Nothing left outstanding
    chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    chk("char_queue_empty", 32'(ch_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tb_ctrl_periph.md
# cv32e40p_tb_ctrl_periph

Memory-mapped testbench control peripheral inside the core testbench subsystem, directly upstream of the top-level testbench's pass/fail/exit monitor. It terminates data-bus writes to the stdout, test-status, exit and timer addresses. It buffers stdout characters in a FIFO and drains them over a valid/ready character stream. It raises `tests_passed_o`, `tests_failed_o` and `exit_valid_o` only after all buffered stdout characters have left, so that no console output is lost at `$finish`.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: stdout FIFO entries; power of two, ≥2.
- `STDOUT_ADDR`, 32'h1000_0000: stdout register word address.
- `STATUS_ADDR`, 32'h2000_0000: test-status register.
- `EXIT_ADDR`, 32'h2000_0004: exit register.
- `TIMER_ADDR`, 32'h1500_0000: timer control (+0) and count (+4).
- `PASS_MAGIC`, 32'd123456789: status value meaning pass.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_i` in 1: data request (OBI).
- `gnt_o` out 1: grant.
- `we_i` in 1: write enable.
- `be_i` in 4: byte enables.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: write data.
- `rvalid_o` out 1: response valid.
- `rdata_o` out 32: read data.
- `char_valid_o` out 1: stdout char available.
- `char_o` out 8: stdout char.
- `char_ready_i` in 1: consumer accepts char.
- `tests_passed_o` out 1: sticky pass.
- `tests_failed_o` out 1: sticky fail.
- `exit_valid_o` out 1: sticky exit.
- `exit_value_o` out 32: exit code.

## Operation
- Address match uses `addr_i[31:2]`; all registers are word-wide.
- **STDOUT write**: pushes `wdata_i[7:0]` into the FIFO; `be_i` is ignored.
- **STATUS write**: `PASS_MAGIC` arms pass; any other value arms fail.
- **EXIT write**: latches `wdata_i` into the pending exit value and arms exit.
- **TIMER+0 write**: bit0=1 clears the count and starts it; bit0=0 stops it.
- **TIMER+4**: read returns the count.
- Unmapped writes are dropped. Unmapped and write-only reads return 0.
- FSM states: RUN, DRAIN, DONE.
  - RUN → DRAIN on the first accepted STATUS or EXIT write.
  - DRAIN → DONE when the FIFO is empty.
  - DONE is terminal until reset.
- First arming wins. Later STATUS/EXIT writes are granted and ignored.
- STDOUT writes are still accepted in DRAIN and are drained before DONE.
- Entering DONE sets exactly one of `tests_passed_o`/`tests_failed_o`/`exit_valid_o`, plus `exit_value_o` if exit was armed. These hold until reset.
- Timer is a 32-bit counter that increments every cycle while running and wraps modulo 2^32.

## Timing
- `gnt_o = req_i & ~(stdout write & FIFO full)`. This is the only combinational path; all other requests are granted in the same cycle.
- `rvalid_o` is asserted exactly one cycle after each grant, for both reads and writes. `rdata_o` is registered and is 0 on writes.
- A char push on a granted cycle is visible on `char_valid_o` the next cycle. The FIFO is a first-word-fall-through register file.
- Pop occurs when `char_valid_o & char_ready_i`.
- FIFO full with a simultaneous push and pop: `gnt_o` stays 0 (conservative). The push waits one cycle.
- FIFO empty: `char_valid_o` = 0; `char_o` holds its last value.
- DRAIN→DONE takes 1 cycle after the final pop. Status outputs rise on the cycle after the FIFO becomes empty.
- Reset values: all outputs 0. FSM=RUN, FIFO empty, timer stopped at 0.
- Reset mid-drain discards all buffered characters and pending status.

## Configuration
- `CV32E40P_TB_CTRL_TIMER_EN` defined: timer registers and counter are present.
- Undefined: no counter flops. TIMER addresses are unmapped (writes dropped, reads 0).

## Structure
- Package `cv32e40p_tb_ctrl_pkg` holds:
  - default address constants;
  - `PASS_MAGIC`;
  - state enum `tb_ctrl_state_e` {RUN, DRAIN, DONE};
  - exit-kind enum {NONE, PASS, FAIL, EXIT}.
- Sub-module `cv32e40p_tb_ctrl_fifo`: parameterised 8-bit synchronous FIFO with `full_o`/`empty_o`, push/pop, and the same `clk_i`/`rst_i`.

## Test plan
- Write "Hi\n" (0x48, 0x69, 0x0A) to STDOUT with `char_ready_i`=1 → chars appear in order, one per cycle, starting 1 cycle after each grant.
- Hold `char_ready_i`=0 and write 17 chars → the first 16 are granted, the 17th sees `gnt_o`=0 until `char_ready_i`=1 frees a slot.
- Buffer 3 chars with ready low, write 123456789 to STATUS, then release ready → `tests_passed_o` rises 1 cycle after the 3rd pop. `tests_failed_o` stays 0.
- Write EXIT=5, then STATUS=1 → `exit_valid_o`=1, `exit_value_o`=5, `tests_failed_o`=0.
- Timer: write 1 to +0, idle 10 cycles, read +4 → value in 10..12. Write 0, read twice → equal values. With the macro undefined → reads return 0.
- Assert `rst_i` during DRAIN with chars buffered → all outputs 0 next cycle. No chars emitted after reset.
